// File: rtl/rom_port_arbiter.sv
// Shares one single-port sync memory between a buffered download write stream and two round-robin CPU readers.
// Reads: req at IDLE edge k -> mem_re k+1 -> ack k+3; writes win at IDLE; dn_wr dropped (sticky flag) when the 2-deep FIFO is full.
module rom_port_arbiter #(
    parameter int AW          = 18,
    parameter int DW          = 8,
    parameter int HOLD_CYCLES = 16
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          dn_download,
    input  logic          dn_wr,
    input  logic [AW-1:0] dn_addr,
    input  logic [DW-1:0] dn_data,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    input  logic          snd_req,
    input  logic [AW-1:0] snd_addr,
    output logic          snd_ack,
    output logic [DW-1:0] snd_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata,
    output logic          cpu_hold,
    output logic          dn_overflow
);

    typedef enum logic [2:0] {IDLE, WR, RD, RDW, ACK} state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_ent_t;

    localparam int HW = $clog2(HOLD_CYCLES + 1);

    state_t        state, state_nxt;
    wr_ent_t       fifo_mem [2];
    wr_ent_t       fifo_head;
    logic          fifo_wp, fifo_rp;
    logic [1:0]    fifo_cnt;
    logic          fifo_empty, fifo_full, fifo_pop, fifo_push;
    logic          req_any, start_rd, sel_snd, gnt_snd, rr_snd;
    logic          we_nxt, re_nxt, cpu_ack_nxt, snd_ack_nxt;
    logic          busy;
    logic [HW-1:0] hold_cnt;

    // Two-entry write buffer; a push into a full buffer survives only if the head pops in the same cycle.
    assign fifo_empty = (fifo_cnt == 2'd0);
    assign fifo_full  = (fifo_cnt == 2'd2);
    assign fifo_push  = dn_wr && (!fifo_full || fifo_pop);
    assign fifo_head  = fifo_mem[fifo_rp];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            fifo_wp  <= 1'b0;
            fifo_rp  <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (fifo_push) fifo_wp <= ~fifo_wp;
            if (fifo_pop)  fifo_rp <= ~fifo_rp;
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (fifo_push) fifo_mem[fifo_wp] <= {dn_addr, dn_data};
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!fifo_empty)  state_nxt = WR;
                else if (req_any) state_nxt = RD;
            end
            WR:      state_nxt = IDLE;
            RD:      state_nxt = RDW;
            RDW:     state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign req_any = cpu_req || snd_req;

    // With both requesting, serve whoever was not granted last (rr_snd=1 means sound was last).
    always_comb begin
        fifo_pop    = (state == IDLE) && !fifo_empty;
        start_rd    = (state == IDLE) && fifo_empty && req_any;
        sel_snd     = snd_req && (!cpu_req || !rr_snd);
        we_nxt      = fifo_pop;
        re_nxt      = start_rd;
        cpu_ack_nxt = (state == RDW) && !gnt_snd;
        snd_ack_nxt = (state == RDW) && gnt_snd;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            cpu_ack   <= 1'b0;
            snd_ack   <= 1'b0;
            cpu_rdata <= '0;
            snd_rdata <= '0;
            gnt_snd   <= 1'b0;
            rr_snd    <= 1'b1;
        end else begin
            mem_we  <= we_nxt;
            mem_re  <= re_nxt;
            cpu_ack <= cpu_ack_nxt;
            snd_ack <= snd_ack_nxt;
            if (fifo_pop) begin
                mem_addr <= fifo_head.addr;
                mem_din  <= fifo_head.data;
            end else if (start_rd) begin
                mem_addr <= sel_snd ? snd_addr : cpu_addr;
                gnt_snd  <= sel_snd;
                rr_snd   <= sel_snd;
            end
            if (state == RDW) begin
                if (gnt_snd) snd_rdata <= mem_rdata;
                else         cpu_rdata <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)                          dn_overflow <= 1'b0;
        else if (dn_wr && fifo_full && !fifo_pop) dn_overflow <= 1'b1;
    end

    // Hold stays up while loading and for HOLD_CYCLES after the last buffered write leaves the FIFO.
    assign busy = dn_download || !fifo_empty;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= HW'(HOLD_CYCLES);
            cpu_hold <= 1'b1;
        end else if (busy) begin
            hold_cnt <= HW'(HOLD_CYCLES);
            cpu_hold <= 1'b1;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
            cpu_hold <= (hold_cnt != HW'(1));
        end else begin
            cpu_hold <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: memory model, write scoreboard and round-robin read scoreboard.
module tb_rom_port_arbiter;

    logic        clk_sys, reset_n;
    logic        dn_download, dn_wr;
    logic [17:0] dn_addr, cpu_addr, snd_addr, mem_addr;
    logic [7:0]  dn_data, cpu_rdata, snd_rdata, mem_din, mem_rdata;
    logic        cpu_req, cpu_ack, snd_req, snd_ack;
    logic        mem_we, mem_re, cpu_hold, dn_overflow;

    rom_port_arbiter #(.AW(18), .DW(8), .HOLD_CYCLES(16)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .dn_download(dn_download), .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_data(dn_data),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .snd_req(snd_req), .snd_addr(snd_addr), .snd_ack(snd_ack), .snd_rdata(snd_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .cpu_hold(cpu_hold), .dn_overflow(dn_overflow)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    function automatic logic [7:0] init_pat(input logic [17:0] a);
        return a[7:0] ^ a[15:8] ^ {6'h15, a[17:16]};
    endfunction

    // Memory behind the DUT; locations never written return init_pat.
    logic [7:0] ram     [0:262143];
    bit         ram_vld [0:262143];
    always @(posedge clk_sys) begin
        if (mem_we) begin
            ram[mem_addr]     <= mem_din;
            ram_vld[mem_addr] <= 1'b1;
        end
        if (mem_re) mem_rdata <= ram_vld[mem_addr] ? ram[mem_addr] : init_pat(mem_addr);
    end

    // Expected memory image, updated by the bench as accepted writes are driven.
    logic [7:0]  exp_mem [0:262143];
    bit          exp_vld [0:262143];
    logic [25:0] wq[$];
    int          total = 0, bad = 0, we_cnt = 0;
    int          n, base;
    bit          quiet_bad, hold_all;
    logic [8:0]  iv;
    logic [17:0] a;

    function automatic logic [7:0] exp_rd(input logic [17:0] ad);
        return exp_vld[ad] ? exp_mem[ad] : init_pat(ad);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drv_wr(input logic [17:0] ad, input logic [7:0] d, input bit accept);
        dn_wr = 1'b1; dn_addr = ad; dn_data = d;
        if (accept) begin
            wq.push_back({ad, d});
            exp_mem[ad] = d;
            exp_vld[ad] = 1'b1;
        end
    endtask

    task automatic chk_reset_outs(input string pfx);
        chk({pfx, "_hold"}, 32'(cpu_hold), 32'(1));
        chk({pfx, "_strobes"}, 32'({mem_we, mem_re, cpu_ack, snd_ack}), 32'(0));
        chk({pfx, "_ovf"}, 32'(dn_overflow), 32'(0));
        chk({pfx, "_addr_din"}, 32'({mem_addr, mem_din}), 32'(0));
        chk({pfx, "_rdata"}, 32'({cpu_rdata, snd_rdata}), 32'(0));
    endtask

    // Counts edges until cpu_hold falls, noting any activity on the other outputs meanwhile.
    task automatic hold_len(output int n_o, output bit q_o);
        n_o = 0; q_o = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk_sys); #1;
            n_o++;
            q_o |= mem_we | mem_re | cpu_ack | snd_ack | dn_overflow;
            if (!cpu_hold) break;
        end
    endtask

    task automatic rr_run(input int nreq);
        bit          ew[$];
        logic [7:0]  ed[$];
        int          got, issued, last;
        bit          first, who, cpu_again, snd_again;
        logic [17:0] ra;
        got = 0; first = 1'b1; cpu_again = 1'b0; snd_again = 1'b0;
        @(negedge clk_sys);
        ra = 18'($urandom); cpu_addr = ra; ew.push_back(1'b0); ed.push_back(exp_rd(ra));
        ra = 18'($urandom); snd_addr = ra; ew.push_back(1'b1); ed.push_back(exp_rd(ra));
        cpu_req = 1'b1; snd_req = 1'b1; issued = 2; last = cyc;
        for (int c = 0; c < nreq * 4 + 20 && got < nreq; c++) begin
            @(negedge clk_sys);
            if (cpu_again) begin
                ra = 18'($urandom); cpu_addr = ra; cpu_req = 1'b1;
                ew.push_back(1'b0); ed.push_back(exp_rd(ra)); issued++; cpu_again = 1'b0;
            end
            if (snd_again) begin
                ra = 18'($urandom); snd_addr = ra; snd_req = 1'b1;
                ew.push_back(1'b1); ed.push_back(exp_rd(ra)); issued++; snd_again = 1'b0;
            end
            if (cpu_ack || snd_ack) begin
                who = snd_ack;
                chk("rr_single_ack", 32'(cpu_ack & snd_ack), 32'(0));
                chk("rr_gap", 32'(cyc - last), first ? 32'd3 : 32'd4);
                chk("rr_pending", 32'(ew.size() != 0), 32'(1));
                if (ew.size() != 0) begin
                    chk("rr_who", 32'(who), 32'(ew.pop_front()));
                    chk("rr_data", 32'(who ? snd_rdata : cpu_rdata), 32'(ed.pop_front()));
                end
                last = cyc; first = 1'b0; got++;
                if (who) begin snd_req = 1'b0; snd_again = (issued < nreq); end
                else     begin cpu_req = 1'b0; cpu_again = (issued < nreq); end
            end
        end
        chk("rr_count", 32'(got), 32'(nreq));
        cpu_req = 1'b0; snd_req = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; dn_download = 1'b0; dn_wr = 1'b0; dn_addr = '0; dn_data = '0;
        cpu_req = 1'b0; cpu_addr = '0; snd_req = 1'b0; snd_addr = '0;

        fork
            forever begin
                @(negedge clk_sys);
                if (reset_n && (mem_we || mem_re))
                    chk("we_re_excl", 32'(mem_we & mem_re), 32'(0));
                if (reset_n && mem_we) begin
                    we_cnt++;
                    chk("wr_pending", 32'(wq.size() != 0), 32'(1));
                    if (wq.size() != 0) chk("wr_entry", 32'({mem_addr, mem_din}), 32'(wq.pop_front()));
                end
            end
        join_none

        // T1: reset release without download
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        chk_reset_outs("t1");
        hold_len(n, quiet_bad);
        chk("t1_hold_len", 32'(n), 32'(16));
        chk("t1_quiet", 32'(quiet_bad), 32'(0));

        // T2: spaced download writes across the address range
        @(negedge clk_sys);
        dn_download = 1'b1; base = we_cnt; hold_all = 1'b1;
        for (int i = 0; i < 512; i++) begin
            iv = 9'(i); a = {iv, iv};
            drv_wr(a, a[7:0], 1'b1);
            @(negedge clk_sys); dn_wr = 1'b0; hold_all &= cpu_hold;
            repeat (3) @(negedge clk_sys);
        end
        chk("t2_we_cnt", 32'(we_cnt - base), 32'(512));
        chk("t2_ovf", 32'(dn_overflow), 32'(0));
        chk("t2_wq_drained", 32'(wq.size()), 32'(0));
        chk("t2_hold", 32'(hold_all), 32'(1));
        dn_download = 1'b0;
        hold_len(n, quiet_bad);
        chk("t2_hold_tail", 32'(n), 32'(16));

        // T5: write arriving during an in-flight read waits for the next IDLE
        @(negedge clk_sys);
        dn_download = 1'b1; cpu_addr = 18'h3FFFF; cpu_req = 1'b1; hold_all = 1'b1;
        @(negedge clk_sys);
        chk("t5_re", 32'(mem_re), 32'(1));
        chk("t5_raddr", 32'(mem_addr), 32'h3FFFF);
        drv_wr(18'h12345, 8'hA5, 1'b1); hold_all &= cpu_hold;
        @(negedge clk_sys); dn_wr = 1'b0; hold_all &= cpu_hold;
        @(negedge clk_sys);
        chk("t5_ack", 32'(cpu_ack), 32'(1));
        chk("t5_data", 32'(cpu_rdata), 32'(exp_rd(18'h3FFFF)));
        cpu_req = 1'b0; hold_all &= cpu_hold;
        @(negedge clk_sys);
        chk("t5_we_wait", 32'(mem_we), 32'(0)); hold_all &= cpu_hold;
        @(negedge clk_sys);
        chk("t5_we", 32'(mem_we), 32'(1));
        chk("t5_waddr", 32'(mem_addr), 32'h12345);
        chk("t5_hold", 32'(hold_all & cpu_hold), 32'(1));

        // T3: four back-to-back strobes, timed so only one pop overlaps them
        @(negedge clk_sys);
        base = we_cnt; snd_addr = 18'h00ABC; snd_req = 1'b1;
        @(negedge clk_sys);
        @(negedge clk_sys); drv_wr(18'h20000, 8'h11, 1'b1);
        @(negedge clk_sys);
        chk("t3_ack", 32'(snd_ack), 32'(1));
        chk("t3_data", 32'(snd_rdata), 32'(exp_rd(18'h00ABC)));
        snd_req = 1'b0; drv_wr(18'h20001, 8'h22, 1'b1);
        @(negedge clk_sys); drv_wr(18'h20002, 8'h33, 1'b1);
        @(negedge clk_sys); drv_wr(18'h20003, 8'h44, 1'b0);
        @(negedge clk_sys); dn_wr = 1'b0;
        chk("t3_ovf", 32'(dn_overflow), 32'(1));
        repeat (6) @(negedge clk_sys);
        chk("t3_we_cnt", 32'(we_cnt - base), 32'(3));
        chk("t3_wq_drained", 32'(wq.size()), 32'(0));
        dn_download = 1'b0;
        hold_len(n, quiet_bad);

        // T4: both CPUs requesting continuously
        rr_run(100);

        // T6: reset in the middle of a read
        @(negedge clk_sys); cpu_addr = 18'h0F0F0; cpu_req = 1'b1;
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b0; #1;
        chk("t6_hold", 32'(cpu_hold), 32'(1));
        chk("t6_no_ack", 32'({cpu_ack, mem_re}), 32'(0));
        chk("t6_ovf_clr", 32'(dn_overflow), 32'(0));
        cpu_req = 1'b0;
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        chk_reset_outs("t6");
        hold_len(n, quiet_bad);
        chk("t6_hold_len", 32'(n), 32'(16));
        chk("t6_quiet", 32'(quiet_bad), 32'(0));
        rr_run(4);

        repeat (4) @(negedge clk_sys);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
